// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared state encoding and sizing for the shift-and-add multiplier.
package mult_ctrl_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
   localparam int WIDTH = 16;
   localparam int CNT_W = 5;
   localparam int STEPS = 16;
endpackage

// File: rtl/Adder_16.sv
// Adder_16: 16-bit ripple adder with carry in/out, the multiplier's only arithmetic resource.
module Adder_16 (
   output logic        cout,
   output logic [15:0] ou,
   input  logic [15:0] in0,
   input  logic [15:0] in1,
   input  logic        cin
);
   assign {cout, ou} = {1'b0, in0} + {1'b0, in1} + {16'b0, cin};
endmodule

// File: rtl/add_shift_mult_ctrl.sv
// add_shift_mult_ctrl: 16x16 unsigned shift-and-add multiplier sequenced over one Adder_16.
// Define MULT_EARLY_TERM_EN to finish early once the remaining multiplier bits are zero.
module add_shift_mult_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   in0,
   input  logic [WIDTH-1:0]   in1,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] ou
);
   import mult_ctrl_pkg::*;

   if (WIDTH != 16) begin : g_bad_width
      $error("add_shift_mult_ctrl: WIDTH must be 16 to match Adder_16");
   end

   state_t               r_state, w_state_nxt;
   logic [WIDTH-1:0]     r_a, r_hi, r_lo, w_sum;
   logic [CNT_W-1:0]     r_cnt, w_k;
   logic [2*WIDTH-1:0]   r_ou, w_step, w_res;
   logic                 w_cout, w_last;

   Adder_16 u_add (
      .cout(w_cout),
      .ou  (w_sum),
      .in0 (r_hi),
      .in1 (r_lo[0] ? r_a : '0),
      .cin (1'b0)
   );

   // carry re-enters at bit 31, so the 33rd bit never needs storing
   assign w_step = {w_cout, w_sum, r_lo[WIDTH-1:1]};
   assign w_k    = r_cnt + 1'b1;

`ifdef MULT_EARLY_TERM_EN
   assign w_last = WIDTH'(w_step[WIDTH-1:0] << w_k) == '0;
   assign w_res  = w_step >> (CNT_W'(STEPS) - w_k);
`else
   assign w_last = w_k == CNT_W'(STEPS);
   assign w_res  = w_step;
`endif

   assign ou = r_ou;

   always_comb begin
      ready       = r_state == S_IDLE;
      busy        = r_state == S_RUN;
      done        = r_state == S_DONE;
      w_state_nxt = r_state == S_IDLE ? (start ? S_RUN : S_IDLE) :
                    r_state == S_RUN  ? (w_last ? S_DONE : S_RUN) : S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_ou    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && start) begin
            r_a   <= in0;
            r_hi  <= '0;
            r_lo  <= in1;
            r_cnt <= '0;
         end else if (r_state == S_RUN) begin
            {r_hi, r_lo} <= w_step;
            r_cnt        <= w_k;
            if (w_last) r_ou <= w_res;
         end
      end
   end
endmodule

// File: tb/tb_add_shift_mult_ctrl.sv
// tb_add_shift_mult_ctrl: directed and random multiplies checked against an arithmetic model.
module tb_add_shift_mult_ctrl;
   logic        clk = 0, reset = 1, start = 0;
   logic [15:0] in0 = 0, in1 = 0;
   logic        ready, busy, done;
   logic [31:0] ou;
   int          n_tests = 0, n_fail = 0;
   logic [31:0] last_ou = 0;

   add_shift_mult_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .in0(in0), .in1(in1),
      .ready(ready), .busy(busy), .done(done), .ou(ou)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_latency(input logic [15:0] b);
`ifdef MULT_EARLY_TERM_EN
      int top = 0;
      for (int i = 0; i < 16; i++) if (b[i]) top = i + 1;
      return (top < 1 ? 1 : top) + 1;
`else
      return 17;
`endif
   endfunction

   task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input bit stray);
      int n;
      @(negedge clk);
      check("idle_ready", ready, 1);
      check("idle_done", done, 0);
      check("idle_hold", ou, last_ou);
      start = 1; in0 = a; in1 = b;
      @(negedge clk);
      start = 0; in0 = $urandom; in1 = $urandom;
      n = 1;
      while (!done && n < 40) begin
         check("run_busy", {ready, busy}, 2'b01);
         if (stray && n == 3) begin start = 1; in0 = 2; in1 = 2; end
         @(negedge clk);
         start = 0;
         n++;
      end
      check("latency", n, exp_latency(b));
      check("product", ou, 32'(a) * 32'(b));
      check("done_ready", ready, 0);
      last_ou = 32'(a) * 32'(b);
      if (stray) begin start = 1; in0 = 2; in1 = 2; end
   endtask

   initial begin
      int pulses;
      logic [15:0] ra, rb;
      #1;
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ou", ou, 0);
      @(negedge clk) reset = 0;
      do_mult(16'd3, 16'd5, 0);
      do_mult(16'hFFFF, 16'hFFFF, 0);
      do_mult(16'd7, 16'd9, 1);
      do_mult(16'h8000, 16'h0002, 0);
      do_mult(16'h00FF, 16'h0101, 0);
      do_mult(16'hABCD, 16'h0003, 0);
      do_mult(16'hABCD, 16'h0000, 0);
      // abort mid-run with reset; the partial product must vanish
      @(negedge clk);
      start = 1; in0 = 16'h1234; in1 = 16'h0010;
      @(negedge clk);
      start = 0;
`ifdef MULT_EARLY_TERM_EN
      repeat (2) @(negedge clk);
`else
      repeat (6) @(negedge clk);
`endif
      check("pre_rst_busy", busy, 1);
      reset = 1;
      #1;
      check("mid_rst_ready", ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ou", ou, 0);
      @(negedge clk) reset = 0;
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("no_done_after_rst", pulses, 0);
      last_ou = 0;
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 5 == 1) rb = rb >> $urandom_range(15, 8);
         if (i % 7 == 2) ra = 16'hFFFF;
         do_mult(ra, rb, 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
